// File: rtl/pg_addsub_pkg.sv
// Shared types and constants for the serial propagate/generate adder/subtractor.
// State encoding, operation codes and chunk-count helpers.
package pg_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Index width that stays legal (>=1 bit) even when a single chunk covers the operand.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    localparam int DEF_N  = 16;
    localparam int DEF_W  = 4;
    localparam int NCHUNK = DEF_N / DEF_W;
    localparam int IDX_W  = idx_width(NCHUNK);

endpackage

// File: rtl/pg_lookahead_chunk.sv
// Combinational W-bit carry-lookahead slice: every carry is a flat sum of products
// of the per-bit propagate/generate terms, so there is no ripple path inside the chunk.
module pg_lookahead_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb,
    output logic         gp,
    output logic         gg
);

    logic [W-1:0] p_s;
    logic [W-1:0] g_s;
    logic [W:0]   c_s;
    logic         grp_g_s;

    // Expand c[i+1] = g_i | p_i g_{i-1} | ... | p_i..p_0 cin directly.
    always_comb begin
        logic term_s;
        logic prod_s;
        p_s     = a ^ b;
        g_s     = a & b;
        c_s     = '0;
        c_s[0]  = cin;
        grp_g_s = 1'b0;
        for (int i = 0; i < W; i++) begin
            term_s = 1'b0;
            for (int j = 0; j <= i; j++) begin
                prod_s = g_s[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod_s = prod_s & p_s[k];
                end
                term_s = term_s | prod_s;
            end
            prod_s = cin;
            for (int k = 0; k <= i; k++) begin
                prod_s = prod_s & p_s[k];
            end
            c_s[i+1] = term_s | prod_s;
            grp_g_s  = term_s;
        end
    end

    // Chunk results.
    always_comb begin
        sum  = p_s ^ c_s[W-1:0];
        cout = c_s[W];
        cmsb = c_s[W-1];
        gp   = &p_s;
        gg   = grp_g_s;
    end

endmodule

// File: rtl/pg_serial_addsub.sv
// Multi-cycle N-bit adder/subtractor resolving W bits per cycle with one lookahead slice.
// Optional macro ADDSUB_SATURATE_EN: replace overflowing results with signed saturation.
module pg_serial_addsub
    import pg_addsub_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CHUNKS = N / W;
    localparam int IDXW   = idx_width(CHUNKS);

    state_e          state_r, state_nxt_s;
    logic [N-1:0]    a_r, a_nxt_s;
    logic [N-1:0]    b_r, b_nxt_s;
    logic            carry_r, carry_nxt_s;
    logic [IDXW-1:0] idx_r, idx_nxt_s;
    logic [N-1:0]    acc_r, acc_nxt_s;
    logic [N-1:0]    sum_r, sum_nxt_s;
    logic            cout_r, cout_nxt_s;
    logic            ovf_r, ovf_nxt_s;
    logic            in_ready_r, in_ready_nxt_s;
    logic            out_valid_r, out_valid_nxt_s;

    logic [W-1:0]    a_ch_s;
    logic [W-1:0]    b_ch_s;
    logic [W-1:0]    ch_sum_s;
    logic            ch_cout_s;
    logic            ch_cmsb_s;
    logic            ch_gp_s;
    logic            ch_gg_s;
    logic [N-1:0]    acc_wr_s;
    logic            last_s;
    logic            ovf_s;

    // Select the active chunk of the latched operands by index.
    always_comb begin
        logic sel_s;
        a_ch_s = '0;
        b_ch_s = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            sel_s  = (idx_r == IDXW'(k));
            a_ch_s = a_ch_s | (a_r[k*W +: W] & {W{sel_s}});
            b_ch_s = b_ch_s | (b_r[k*W +: W] & {W{sel_s}});
        end
    end

    pg_lookahead_chunk #(.W(W)) u_chunk (
        .a    (a_ch_s),
        .b    (b_ch_s),
        .cin  (carry_r),
        .sum  (ch_sum_s),
        .cout (ch_cout_s),
        .cmsb (ch_cmsb_s),
        .gp   (ch_gp_s),
        .gg   (ch_gg_s)
    );

    // Merge the freshly resolved chunk into the accumulator image.
    always_comb begin
        logic sel_s;
        acc_wr_s = acc_r;
        for (int k = 0; k < CHUNKS; k++) begin
            sel_s = (idx_r == IDXW'(k));
            acc_wr_s[k*W +: W] = sel_s ? ch_sum_s : acc_r[k*W +: W];
        end
        last_s = (idx_r == IDXW'(CHUNKS - 1));
        ovf_s  = ch_cmsb_s ^ ch_cout_s;
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        carry_nxt_s = carry_r;
        idx_nxt_s   = idx_r;
        acc_nxt_s   = acc_r;
        sum_nxt_s   = sum_r;
        cout_nxt_s  = cout_r;
        ovf_nxt_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    a_nxt_s     = a;
                    b_nxt_s     = (sub == OP_SUB) ? ~b : b;
                    carry_nxt_s = sub;
                    idx_nxt_s   = '0;
                    acc_nxt_s   = '0;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                acc_nxt_s   = acc_wr_s;
                // Group P/G give the chunk carry-out without waiting on the per-bit carries.
                carry_nxt_s = ch_gg_s | (ch_gp_s & carry_r);
                if (last_s) begin
                    idx_nxt_s   = '0;
                    cout_nxt_s  = ch_cout_s;
                    ovf_nxt_s   = ovf_s;
                    state_nxt_s = DONE;
`ifdef ADDSUB_SATURATE_EN
                    // Carry out set means both inputs were negative: clamp to most negative.
                    if (ovf_s) begin
                        sum_nxt_s = ch_cout_s ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                    end else begin
                        sum_nxt_s = acc_wr_s;
                    end
`else
                    sum_nxt_s   = acc_wr_s;
`endif
                end else begin
                    idx_nxt_s   = idx_r + IDXW'(1);
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        in_ready_nxt_s  = (state_nxt_s == IDLE);
        out_valid_nxt_s = (state_nxt_s == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            idx_r       <= '0;
            acc_r       <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            carry_r     <= carry_nxt_s;
            idx_r       <= idx_nxt_s;
            acc_r       <= acc_nxt_s;
            sum_r       <= sum_nxt_s;
            cout_r      <= cout_nxt_s;
            ovf_r       <= ovf_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pg_serial_addsub.sv
// Directed self-checking bench for pg_serial_addsub (N=16, W=4).
module tb_pg_serial_addsub;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int pass_cnt;
    int total_cnt;

    pg_serial_addsub #(.N(16), .W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, check latency and result, then hand it off.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                          input string name);
        int cyc;
        a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL %s busy: in_ready=%b required 0", name, in_ready);
        else pass_cnt++;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        total_cnt++;
        if (cyc !== 4) $display("FAIL %s latency: got %0d required 4", name, cyc);
        else pass_cnt++;
        total_cnt++;
        if (sum !== exp_sum || cout !== exp_cout || ovf !== exp_ovf)
            $display("FAIL %s result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, exp_sum, exp_cout, exp_ovf);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s handoff: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0)
            $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        else pass_cnt++;
    endtask

    task automatic test_arith();
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_noborrow");
`ifdef ADDSUB_SATURATE_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "add_posovf");
`else
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_posovf");
`endif
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
        run_op(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, "add_chunkcarry");
`ifdef ADDSUB_SATURATE_EN
        run_op(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, "sub_negovf");
`else
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_negovf");
`endif
    endtask

    task automatic test_backpressure();
        int cyc;
        a = 16'h1234; b = 16'h4321; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        total_cnt++;
        if (cyc !== 4) $display("FAIL bp_latency: got %0d required 4", cyc);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            a = 16'hAAAA; b = 16'h1111; in_valid = (i % 2 == 0);
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h5555 || cout !== 1'b0)
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h cout=%b required 1 0 5555 0",
                         i, out_valid, in_ready, sum, cout);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        a = 16'h0100; b = 16'h0020; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        total_cnt++;
        if (sum !== 16'h0120) $display("FAIL b2b_first: sum=%h required 0120", sum);
        else pass_cnt++;
        a = 16'h0003; b = 16'h0009; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL b2b_noaccept: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL b2b_accept: in_ready=%b required 0", in_ready);
        else pass_cnt++;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        total_cnt++;
        if (cyc !== 4 || sum !== 16'hFFFA || cout !== 1'b0)
            $display("FAIL b2b_second: lat=%0d sum=%h cout=%b required 4 FFFA 0", cyc, sum, cout);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_in_run();
        a = 16'h2222; b = 16'h3333; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000)
            $display("FAIL rst_run: in_ready=%b out_valid=%b sum=%h required 1 0 0000",
                     in_ready, out_valid, sum);
        else pass_cnt++;
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after_rst");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_in_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pg_serial_addsub.md
Name: pg_serial_addsub

Overview:
- Multi-cycle N-bit adder/subtractor; consumes per-bit propagate/generate terms W bits per cycle.
- Resolves each W-bit chunk's carries by lookahead; a carry register links successive chunks.
- Serves the approximate multiplier's low-power datapath as the area-lean counterpart to the parallel lookahead adder, e.g. final partial-product accumulation and error-compensation subtraction.
- Valid/ready handshake on both sides.

Parameters:
- N, 16, operand/result width; must be a multiple of W.
- W, 4, chunk width processed per cycle; lookahead depth per cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op valid.
- in_ready  output  1  block can accept an operation.
- a  input  N  operand A (two's complement for overflow purposes).
- b  input  N  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- sum  output  N  result.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0; chunk index=0; carry reg=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, latch (sub ? ~b : b), carry reg<=sub, idx<=0, sum<=0, go RUN.
- RUN:
  - in_ready=0.
  - Per cycle, on chunk idx: p_i=a_i^b_i; g_i=a_i&b_i; c_{i+1}=g_i|(p_i&c_i) using lookahead terms from the carry reg; sum_i=p_i^c_i.
  - Write the chunk into sum[idx*W +: W]; carry reg<=chunk carry out; idx++.
  - On idx==N/W-1: also capture carry into MSB and carry out, set cout/ovf, go DONE.
- DONE:
  - out_valid=1; sum/cout/ovf stable.
  - On out_ready: out_valid<=0, go IDLE.
- Latency: out_valid rises exactly N/W cycles after the accepting edge (4 for defaults).
- Throughput: one op per N/W+2 cycles minimum. DONE→IDLE always costs one cycle; no accept in the same cycle as result handoff.
- in_valid outside IDLE is ignored. Upstream holds its data; no operation is lost, since in_ready=0.
- Any out_ready held low in DONE holds the result indefinitely, unchanged.
- rst asserted in RUN or DONE discards the op; next cycle matches the reset state.
- N==W: single RUN cycle; latency 1.
- Outputs sum/cout/ovf are registered and change only on the DONE entry edge or reset.

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- Defined: on ovf=1, sum is replaced at DONE entry by signed saturation. Positive overflow → 0x7FFF..., negative overflow → 0x8000...; ovf still reported; cout unchanged.
- Undefined: sum is the raw modulo-2^N result; no saturation logic.

Decomposition:
- Shared package pg_addsub_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Op encoding constants OP_ADD=0, OP_SUB=1.
  - Localparam NCHUNK=N/W and index width clog2(NCHUNK).
- Sub-module pg_lookahead_chunk, purely combinational, W-bit:
  - Inputs: a chunk, b chunk, cin.
  - Outputs: sum chunk, cout, carry into the chunk MSB, group P, group G.
  - Carries expanded as sum-of-products of p/g, not rippled.
  - Instantiated once; the top muxes the chunk by idx.

Test Plan:
- Add 0x1234+0x4321, sub=0 → sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Sub 0x0005-0x0007 → sum=0xFFFE, cout=0 (borrow), ovf=0. Sub 0x0007-0x0005 → 0x0002, cout=1.
- Add 0x7FFF+0x0001 → sum=0x8000, ovf=1, cout=0 (with ADDSUB_SATURATE_EN: sum=0x7FFF). Add 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0.
- Carry across every chunk boundary: 0x0FFF+0x0001 → 0x1000. Sub 0x8000-0x0001 → 0x7FFF, ovf=1 (saturated build: 0x8000).
- Backpressure: out_ready low 5 cycles in DONE → sum/out_valid stable, in_ready=0; in_valid pulses meanwhile are not accepted.
- rst asserted in cycle 2 of RUN → next cycle state IDLE, in_ready=1, out_valid=0, sum=0. A following op 0x0001+0x0001 returns 0x0002 with normal latency.
